// File: rtl/alu_mul_sequencer_if.sv
// Request/response and ALU-drive signals of the shift-and-add multiplier.
// master = the multiplier; slave = the requester plus the external ALU.
interface alu_mul_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] product;
    logic [WIDTH-1:0] alu_src_a;
    logic [WIDTH-1:0] alu_src_b;
    logic [2:0]       alu_control;
    logic [WIDTH-1:0] alu_result;

    modport master (
        input  start, op_a, op_b, alu_result,
        output busy, done, product, alu_src_a, alu_src_b, alu_control
    );

    modport slave (
        output start, op_a, op_b, alu_result,
        input  busy, done, product, alu_src_a, alu_src_b, alu_control
    );
endinterface

// File: rtl/alu_mul_sequencer.sv
// Multi-cycle multiplier that borrows the EX-stage ALU: one ADD per RUN cycle,
// low WIDTH bits of op_a*op_b, early exit once the remaining multiplier is zero.
module alu_mul_sequencer #(
    parameter int         WIDTH   = 32,
    parameter logic [2:0] ALU_ADD = 3'b010
) (
    input  logic                clk,
    input  logic                rst,
    alu_mul_sequencer_if.master bus
);
    localparam int CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             state_r;
    logic [WIDTH-1:0]   acc_r;
    logic [WIDTH-1:0]   mcand_r;
    logic [WIDTH-1:0]   mplier_r;
    logic [CNT_W-1:0]   count_r;
    logic               busy_r;
    logic               done_r;
    logic [WIDTH-1:0]   product_r;
    logic [WIDTH-1:0]   src_a_r;
    logic [WIDTH-1:0]   src_b_r;

    logic [WIDTH-1:0]   mcand_next_s;
    logic [WIDTH-1:0]   mplier_next_s;
    logic               last_s;

    assign mcand_next_s  = mcand_r << 1;
    assign mplier_next_s = mplier_r >> 1;
    assign last_s        = (mplier_next_s == {WIDTH{1'b0}}) ||
                           (count_r == CNT_W'(WIDTH - 1));

    // ALU operands are registered one cycle ahead, so they always equal
    // acc and (mplier[0] ? mcand : 0) for the RUN cycle being presented.
    // Sequencer state, datapath registers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            acc_r     <= {WIDTH{1'b0}};
            mcand_r   <= {WIDTH{1'b0}};
            mplier_r  <= {WIDTH{1'b0}};
            count_r   <= {CNT_W{1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            product_r <= {WIDTH{1'b0}};
            src_a_r   <= {WIDTH{1'b0}};
            src_b_r   <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        state_r  <= ST_RUN;
                        busy_r   <= 1'b1;
                        mcand_r  <= bus.op_a;
                        mplier_r <= bus.op_b;
                        acc_r    <= {WIDTH{1'b0}};
                        count_r  <= {CNT_W{1'b0}};
                        src_a_r  <= {WIDTH{1'b0}};
                        src_b_r  <= bus.op_b[0] ? bus.op_a : {WIDTH{1'b0}};
                    end else begin
                        state_r  <= ST_IDLE;
                        busy_r   <= 1'b0;
                        src_a_r  <= {WIDTH{1'b0}};
                        src_b_r  <= {WIDTH{1'b0}};
                    end
                end
                ST_RUN: begin
                    acc_r    <= bus.alu_result;
                    mcand_r  <= mcand_next_s;
                    mplier_r <= mplier_next_s;
                    count_r  <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
                    if (last_s) begin
                        state_r   <= ST_DONE;
                        busy_r    <= 1'b0;
                        done_r    <= 1'b1;
                        product_r <= bus.alu_result;
                        src_a_r   <= {WIDTH{1'b0}};
                        src_b_r   <= {WIDTH{1'b0}};
                    end else begin
                        state_r   <= ST_RUN;
                        busy_r    <= 1'b1;
                        done_r    <= 1'b0;
                        src_a_r   <= bus.alu_result;
                        src_b_r   <= mplier_r[1] ? mcand_next_s : {WIDTH{1'b0}};
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                    done_r  <= 1'b0;
                    src_a_r <= {WIDTH{1'b0}};
                    src_b_r <= {WIDTH{1'b0}};
                end
            endcase
        end
    end

    assign bus.busy        = busy_r;
    assign bus.done        = done_r;
    assign bus.product     = product_r;
    assign bus.alu_src_a   = src_a_r;
    assign bus.alu_src_b   = src_b_r;
    assign bus.alu_control = ALU_ADD;
endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Scoreboard bench for alu_mul_sequencer: directed multiplies push expected
// {product, RUN length}; a negedge monitor pops and checks on every done pulse.
module tb_alu_mul_sequencer;
    logic clk = 1'b0;
    logic rst;
    int   cyc   = 0;
    int   total = 0;
    int   bad   = 0;

    typedef struct {
        logic [31:0] prod;
        int          k;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] alu_q[$];
    int          stamp_q[$];
    int          busy_cnt = 0;

    alu_mul_sequencer_if #(.WIDTH(32)) bus ();

    alu_mul_sequencer #(.WIDTH(32), .ALU_ADD(3'b010)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // external ALU: only ADD is exercised
    assign bus.alu_result = (bus.alu_control == 3'b010) ? (bus.alu_src_a + bus.alu_src_b) : 32'h0;

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor / scoreboard
    initial forever begin
        @(negedge clk);
        if (rst === 1'b1) begin
            stamp_q.delete();
            busy_cnt = 0;
        end else begin
            if (bus.busy === 1'b1) begin
                busy_cnt++;
                if (alu_q.size() > 0) begin
                    chk("alu_src_b", bus.alu_src_b, alu_q.pop_front());
                    chk("alu_control_run", {29'd0, bus.alu_control}, 32'd2);
                end
            end
            if (bus.done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done=1 expected done=0 (cycle %0d)", cyc);
                end else begin
                    exp_t e;
                    int   lat;
                    e = exp_q.pop_front();
                    chk("product", bus.product, e.prod);
                    chk("busy_cycles", busy_cnt, e.k);
                    lat = (stamp_q.size() > 0) ? (cyc - stamp_q.pop_front()) : -1;
                    chk("done_latency", lat, e.k + 1);
                end
                busy_cnt = 0;
            end
            if (bus.start === 1'b1 && bus.busy === 1'b0)
                stamp_q.push_back(cyc);
        end
    end

    task automatic wait_empty(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL timeout_%s: got %0d pending results expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] p, input int k);
        @(posedge clk); #2;
        bus.op_a  = a;
        bus.op_b  = b;
        bus.start = 1'b1;
        exp_q.push_back('{prod: p, k: k});
        @(posedge clk); #2;
        bus.start = 1'b0;
        wait_empty(name);
    endtask

    initial begin
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.op_a  = 32'h0;
        bus.op_b  = 32'h0;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_product", bus.product, 32'd0);
        chk("rst_alu_control", {29'd0, bus.alu_control}, 32'd2);
        chk("rst_alu_src_a", bus.alu_src_a, 32'd0);
        chk("rst_alu_src_b", bus.alu_src_b, 32'd0);

        alu_q.push_back(32'd3);
        alu_q.push_back(32'd0);
        alu_q.push_back(32'd12);
        run_op("3x5", 32'd3, 32'd5, 32'd15, 3);
        repeat (3) @(posedge clk);
        #2;
        chk("hold_product", bus.product, 32'd15);
        chk("idle_alu_src_a", bus.alu_src_a, 32'd0);
        chk("idle_alu_src_b", bus.alu_src_b, 32'd0);

        run_op("x0", 32'h1234, 32'h0, 32'h0, 1);
        run_op("x1", 32'h1234, 32'h1, 32'h1234, 1);
        run_op("ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001, 32);
        run_op("7x8000", 32'd7, 32'h8000_0000, 32'h8000_0000, 32);

        // start held through RUN with new operands; the DONE-cycle start launches 2*2
        @(posedge clk); #2;
        bus.op_a  = 32'd6;
        bus.op_b  = 32'd7;
        bus.start = 1'b1;
        exp_q.push_back('{prod: 32'd42, k: 3});
        @(posedge clk); #2;
        bus.op_a = 32'd2;
        bus.op_b = 32'd2;
        exp_q.push_back('{prod: 32'd4, k: 2});
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #2;
            if (exp_q.size() <= 1) break;
        end
        bus.start = 1'b0;
        wait_empty("b2b");

        // abort 9*0xFF on its second RUN cycle
        @(posedge clk); #2;
        bus.op_a  = 32'd9;
        bus.op_b  = 32'hFF;
        bus.start = 1'b1;
        @(posedge clk); #2;
        bus.start = 1'b0;
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0;
        chk("abort_busy", {31'd0, bus.busy}, 32'd0);
        chk("abort_done", {31'd0, bus.done}, 32'd0);
        chk("abort_product", bus.product, 32'd0);
        repeat (12) @(posedge clk);

        run_op("9xff", 32'd9, 32'hFF, 32'h8F7, 8);
        repeat (2) @(posedge clk);
        #2;
        chk("final_product_hold", bus.product, 32'h8F7);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish before 200000 time units");
        $fatal(1, "watchdog expired");
    end
endmodule
